// File: rtl/seq_extrema_pkg.sv
// Shared types and default parameter values for the sequence extrema tracker.
package seq_extrema_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECEIVING = 2'd1,
    DONE      = 2'd2
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam bit DEF_SIGNED_MODE = 1'b0;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/extrema_cmp.sv
// Combinational magnitude compare of a new sample against the running max/min.
module extrema_cmp
  import seq_extrema_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter bit SIGNED_MODE = DEF_SIGNED_MODE
) (
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] cur_max,
  input  logic [WIDTH-1:0] cur_min,
  output logic             gt,
  output logic             lt
);

  logic signed [WIDTH-1:0] s_sample;
  logic signed [WIDTH-1:0] s_max;
  logic signed [WIDTH-1:0] s_min;

  assign s_sample = sample;
  assign s_max    = cur_max;
  assign s_min    = cur_min;

  // Strict greater/less flags; ties report neither so the earlier index is kept.
  always_comb begin
    if (SIGNED_MODE) begin
      gt = s_sample > s_max;
      lt = s_sample < s_min;
    end else begin
      gt = sample > cur_max;
      lt = sample < cur_min;
    end
  end

endmodule

// File: rtl/seq_extrema.sv
// Tracks max/min value and their indices over a start-framed sample sequence.
module seq_extrema
  import seq_extrema_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter bit SIGNED_MODE = DEF_SIGNED_MODE,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] max_value,
  output logic [WIDTH-1:0] min_value,
  output logic [CNT_W-1:0] max_index,
  output logic [CNT_W-1:0] min_index,
  output logic [CNT_W-1:0] sample_count,
  output logic             count_ovf,
  output logic             empty,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] IDX_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic             got;
  logic             accept;
  logic             first;
  logic             sat;
  logic             gt;
  logic             lt;
  logic             to_done;
  logic [CNT_W-1:0] new_idx;

  // Once the counter saturates, new extrema report the last representable index.
  assign accept  = start && in_valid && (state != DONE);
  assign first   = (state == IDLE) || !got;
  assign sat     = (sample_count == CNT_MAX);
  assign new_idx = sat ? IDX_LAST : sample_count;
  assign to_done = (state == RECEIVING) && !start;

  extrema_cmp #(
    .WIDTH       (WIDTH),
    .SIGNED_MODE (SIGNED_MODE)
  ) u_cmp (
    .sample  (in_data),
    .cur_max (max_value),
    .cur_min (min_value),
    .gt      (gt),
    .lt      (lt)
  );

  // Next-state: start opens and holds a frame; DONE always returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = start ? RECEIVING : IDLE;
      RECEIVING: state_nxt = start ? RECEIVING : DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State register with done registered as "state is DONE".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == DONE);
    end
  end

  // Result registers: first accept reloads, later accepts track strict extrema.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      got          <= 1'b0;
      max_value    <= '0;
      min_value    <= '0;
      max_index    <= '0;
      min_index    <= '0;
      sample_count <= '0;
      count_ovf    <= 1'b0;
      empty        <= 1'b0;
    end else if (accept) begin
      got <= 1'b1;
      if (first) begin
        max_value    <= in_data;
        min_value    <= in_data;
        max_index    <= '0;
        min_index    <= '0;
        sample_count <= CNT_ONE;
        count_ovf    <= 1'b0;
      end else begin
        if (gt) begin
          max_value <= in_data;
          max_index <= new_idx;
        end
        if (lt) begin
          min_value <= in_data;
          min_index <= new_idx;
        end
        if (sat) begin
          count_ovf <= 1'b1;
        end else begin
          sample_count <= sample_count + CNT_ONE;
        end
      end
    end else if (to_done) begin
      got   <= 1'b0;
      empty <= !got;
      if (!got) begin
        max_value    <= '0;
        min_value    <= '0;
        max_index    <= '0;
        min_index    <= '0;
        sample_count <= '0;
        count_ovf    <= 1'b0;
      end
    end else if (state != RECEIVING) begin
      got <= 1'b0;
    end
  end

endmodule

// File: doc/seq_extrema.md
SEQ_EXTREMA -- requirements
Module: seq_extrema

Interface
REQ-001 Parameter WIDTH, default 8: sample width in bits.
REQ-002 Parameter SIGNED_MODE, default 0: 0 = unsigned compare, 1 = two's-complement compare.
REQ-003 Parameter CNT_W, default 8: width of the sample counter and index outputs.
REQ-004 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-005 Port reset, input, 1: reset, asynchronous, active-high.
REQ-006 Port start, input, 1: sequence frame; held high for the duration of a sequence.
REQ-007 Port in_valid, input, 1: qualifies in_data in the current cycle.
REQ-008 Port in_data, input, WIDTH: sample value.
REQ-009 Port max_value, output, WIDTH: running or final maximum.
REQ-010 Port min_value, output, WIDTH: running or final minimum.
REQ-011 Port max_index, output, CNT_W: zero-based sample index of max_value.
REQ-012 Port min_index, output, CNT_W: zero-based sample index of min_value.
REQ-013 Port sample_count, output, CNT_W: number of accepted samples in the current or last sequence.
REQ-014 Port count_ovf, output, 1: sticky per sequence; set when more than 2^CNT_W-1 samples are offered.
REQ-015 Port empty, output, 1: last completed sequence had zero accepted samples.
REQ-016 Port done, output, 1: one-cycle pulse marking that the results are final.

Function
REQ-017 The block SHALL implement three registered states: IDLE, RECEIVING, DONE.
REQ-018 The FSM SHALL move IDLE->RECEIVING when start=1, otherwise stay in IDLE.
REQ-019 The FSM SHALL stay in RECEIVING while start=1 and move to DONE when start=0.
REQ-020 The FSM SHALL move DONE->IDLE unconditionally; start is ignored in DONE, so a new sequence needs start high in IDLE.
REQ-021 A sample SHALL be accepted when start=1 and in_valid=1 in IDLE or RECEIVING, including the IDLE cycle in which start first rises.
REQ-022 The first accepted sample of a sequence SHALL load max_value and min_value, set both indices to 0 and set sample_count to 1, discarding the previous sequence's results.
REQ-023 Each later accepted sample SHALL replace max_value only if strictly greater, and min_value only if strictly less; the index updates with the value, so ties keep the earliest index.
REQ-024 Comparison SHALL be signed when SIGNED_MODE=1 and unsigned otherwise; results keep WIDTH bits with no extension.
REQ-025 All outputs SHALL be registered; an accepted sample is reflected in them on the following clock edge, giving one-cycle latency.
REQ-026 sample_count SHALL saturate at 2^CNT_W-1; an accept at saturation SHALL set count_ovf and still update min/max, with the indices frozen at saturation.
REQ-027 done SHALL be 1 exactly while the state is DONE, giving a one-cycle pulse one clock after the cycle in which start was sampled low.
REQ-028 empty SHALL be set on entry to DONE if sample_count=0, with max_value and min_value reading 0; otherwise empty=0.
REQ-029 Results SHALL hold unchanged from DONE until the first accepted sample of the next sequence.
REQ-030 A start pulse of one cycle SHALL produce: IDLE accept (if valid), RECEIVING for one cycle, then DONE.
REQ-031 A gap with in_valid=0 while start=1 SHALL leave all results and the count unchanged.

Reset
REQ-032 Asserting reset SHALL asynchronously force state=IDLE and clear every output and internal register to 0, including done, empty and count_ovf.
REQ-033 Reset asserted mid-sequence SHALL abort it with no done pulse; after release the block SHALL wait in IDLE for start.

Structure
REQ-034 A shared package seq_extrema_pkg SHALL hold the state enum type (IDLE, RECEIVING, DONE) and the default parameter constants.
REQ-035 A sub-module extrema_cmp (combinational, WIDTH and SIGNED_MODE parameters) SHALL produce the greater-than and less-than flags; seq_extrema instantiates it once.
REQ-036 Next-state logic SHALL be combinational (always_comb) with a defined default; state and outputs SHALL be in always_ff blocks.

Verification
REQ-037 Unsigned, WIDTH=8: start high 5 cycles with valid samples 3,9,9,1,7, then start low -> max=9, max_index=1, min=1, min_index=3, count=5, one done pulse.
REQ-038 SIGNED_MODE=1: samples 0x05,0xF0,0x7F,0x80 -> max=0x7F, index 2; min=0x80, index 3; the same stimulus unsigned gives max=0xF0, min=0x05.
REQ-039 Empty frame: start high 3 cycles with in_valid=0 -> done pulse, empty=1, count=0, max=min=0.
REQ-040 Saturation, CNT_W=2: 5 valid samples 1,2,3,4,0 -> count=3, count_ovf=1, max=4, min=0, indices frozen at 2.
REQ-041 Reset mid-sequence: reset asserted after 2 samples -> all outputs 0 on the next sample point, no done pulse; a following sequence of 6,2 -> max=6, min=2.
REQ-042 Back-to-back: second sequence starts the cycle after DONE with sample 4 -> prior results are held through DONE, and max=min=4 after the first accept.
